// File: rtl/copperv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : copperv_pkg
// Description : Shared types for the multi-cycle execution unit: decoded
//               opcode enum, ALU operation enum, EXU state enum and the
//               funct3/funct7 encodings used during decode.
// Revision    : 1.0 - initial release
// ============================================================================
package copperv_pkg;

    // Opcodes arrive pre-decoded; only LOAD, STORE, OP_IMM and OP are
    // executed here, everything else is reported as illegal.
    typedef enum logic [3:0] {
        OPC_LOAD     = 4'd0,
        OPC_STORE    = 4'd1,
        OPC_OP_IMM   = 4'd2,
        OPC_OP       = 4'd3,
        RESERVED_4   = 4'd4,
        OPC_LUI      = 4'd5,
        OPC_AUIPC    = 4'd6,
        OPC_JAL      = 4'd7,
        OPC_JALR     = 4'd8,
        OPC_BRANCH   = 4'd9,
        OPC_MISC_MEM = 4'd10,
        OPC_SYSTEM   = 4'd11
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        EXU_IDLE     = 2'd0,
        EXU_EX       = 2'd1,
        EXU_MEM_WAIT = 2'd2
    } exu_state_e;

    localparam logic [2:0] c_f3_add_sub = 3'b000;
    localparam logic [2:0] c_f3_sll     = 3'b001;
    localparam logic [2:0] c_f3_slt     = 3'b010;
    localparam logic [2:0] c_f3_sltu    = 3'b011;
    localparam logic [2:0] c_f3_xor     = 3'b100;
    localparam logic [2:0] c_f3_sr      = 3'b101;
    localparam logic [2:0] c_f3_or      = 3'b110;
    localparam logic [2:0] c_f3_and     = 3'b111;
    localparam logic [2:0] c_f3_word    = 3'b010;

    localparam logic [6:0] c_f7_base    = 7'h00;
    localparam logic [6:0] c_f7_alt     = 7'h20;

endpackage
`default_nettype wire

// File: rtl/copperv_alu.sv
`default_nettype none
// ============================================================================
// Module      : copperv_alu
// Description : Purely combinational RV32I-style integer ALU at XLEN bits.
//   op      in  alu_op_e   operation select
//   a, b    in  XLEN       operands (b doubles as shift amount source)
//   result  out XLEN       operation result
// Revision    : 1.0 - initial release
// ============================================================================
module copperv_alu
    import copperv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_e          op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    output logic [XLEN-1:0]  result
);

    localparam int c_shamt_w = $clog2(XLEN);

    logic [c_shamt_w-1:0] w_shamt;
    logic                 w_lt_signed;
    logic                 w_lt_unsigned;

    // Only the low log2(XLEN) bits of the second operand select the shift.
    assign w_shamt       = b[c_shamt_w-1:0];
    assign w_lt_signed   = $signed(a) < $signed(b);
    assign w_lt_unsigned = a < b;

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << w_shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, w_lt_signed};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, w_lt_unsigned};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> w_shamt;
            ALU_SRA:  result = $signed(a) >>> w_shamt;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/execution_unit_mc.sv
`default_nettype none
// ============================================================================
// Module      : execution_unit_mc
// Description : Multi-cycle execution unit. Accepts one decoded instruction
//               per cycle into a single EX stage, executes ALU ops with
//               same-cycle writeback, and stalls in MEM_WAIT for word
//               loads/stores until the bus acknowledges.
//   clk, rst                       clock, synchronous active-high reset
//   instr_*  / instr_ready         instruction handshake (valid & ready)
//   bus_cmd_* / bus_rsp_*          memory command and response
//   regfile_cmd_* / regfile_rsp_*  register read addresses, writeback port
//   illegal_instr                  one-cycle pulse for unsupported encodings
// Revision    : 1.0 - initial release
// ============================================================================
module execution_unit_mc
    import copperv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int MEM_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  opcode_e           instr_opcode,
    input  logic [REG_AW-1:0] instr_rd,
    input  logic [REG_AW-1:0] instr_rs1,
    input  logic [REG_AW-1:0] instr_rs2,
    input  logic [XLEN-1:0]   instr_imm,
    input  logic [9:0]        instr_funct,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [XLEN-1:0]   bus_cmd_addr,
    output logic [XLEN-1:0]   bus_cmd_wdata,
    output logic              bus_cmd_en,
    output logic              bus_cmd_we,
    input  logic [XLEN-1:0]   bus_rsp_rdata,
    input  logic              bus_rsp_ready,
    output logic [REG_AW-1:0] regfile_cmd_rs1,
    output logic [REG_AW-1:0] regfile_cmd_rs2,
    output logic [REG_AW-1:0] regfile_cmd_rd,
    output logic [XLEN-1:0]   regfile_cmd_rd_data,
    output logic              regfile_cmd_rd_en,
    input  logic [XLEN-1:0]   regfile_rsp_rs1_data,
    input  logic [XLEN-1:0]   regfile_rsp_rs2_data,
    output logic              illegal_instr
);

    // EX stage registers
    exu_state_e        r_state;
    exu_state_e        w_state_next;
    logic              r_ex_valid;
    opcode_e           r_ex_opcode;
    logic [REG_AW-1:0] r_ex_rd;
    logic [XLEN-1:0]   r_ex_imm;
    logic [9:0]        r_ex_funct;

    // Bus command hold registers keep addr/wdata stable through MEM_WAIT,
    // since the regfile read data is only valid during the EX cycle.
    logic [XLEN-1:0]   r_bus_addr;
    logic [XLEN-1:0]   r_bus_wdata;

    logic              w_mem_supported;
    logic              w_legal;
    logic              w_is_load;
    logic              w_is_store;
    logic              w_is_mem;
    logic              w_use_imm;
    alu_op_e           w_alu_op;
    logic [XLEN-1:0]   w_alu_b;
    logic [XLEN-1:0]   w_alu_result;
    logic [6:0]        w_f7;
    logic [2:0]        w_f3;
    logic              w_in_ex;
    logic              w_accept;
    logic              w_cmd_fire;
    logic              w_alu_wb;
    logic              w_load_wb;
    logic              w_rd_nonzero;

    generate
        if (MEM_EN != 0) begin : g_mem_en
            assign w_mem_supported = 1'b1;
        end else begin : g_mem_dis
            assign w_mem_supported = 1'b0;
        end
    endgenerate

    assign w_f7 = r_ex_funct[9:3];
    assign w_f3 = r_ex_funct[2:0];

    // Decode of the instruction held in EX.
    always_comb begin
        w_legal    = 1'b0;
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_use_imm  = 1'b1;
        w_alu_op   = ALU_ADD;
        case (r_ex_opcode)
            OPC_OP_IMM: begin
                w_legal = 1'b1;
                case (w_f3)
                    c_f3_add_sub: w_alu_op = ALU_ADD;
                    c_f3_slt:     w_alu_op = ALU_SLT;
                    c_f3_sltu:    w_alu_op = ALU_SLTU;
                    c_f3_xor:     w_alu_op = ALU_XOR;
                    c_f3_or:      w_alu_op = ALU_OR;
                    c_f3_and:     w_alu_op = ALU_AND;
                    c_f3_sll: begin
                        w_alu_op = ALU_SLL;
                        w_legal  = (w_f7 == c_f7_base);
                    end
                    c_f3_sr: begin
                        w_alu_op = (w_f7 == c_f7_alt) ? ALU_SRA : ALU_SRL;
                        w_legal  = (w_f7 == c_f7_base) || (w_f7 == c_f7_alt);
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_OP: begin
                w_use_imm = 1'b0;
                // Only ADD/SUB and SRL/SRA have an alternate funct7 form.
                w_legal   = (w_f7 == c_f7_base) ||
                            ((w_f7 == c_f7_alt) &&
                             ((w_f3 == c_f3_add_sub) || (w_f3 == c_f3_sr)));
                case (w_f3)
                    c_f3_add_sub: w_alu_op = (w_f7 == c_f7_alt) ? ALU_SUB : ALU_ADD;
                    c_f3_sll:     w_alu_op = ALU_SLL;
                    c_f3_slt:     w_alu_op = ALU_SLT;
                    c_f3_sltu:    w_alu_op = ALU_SLTU;
                    c_f3_xor:     w_alu_op = ALU_XOR;
                    c_f3_sr:      w_alu_op = (w_f7 == c_f7_alt) ? ALU_SRA : ALU_SRL;
                    c_f3_or:      w_alu_op = ALU_OR;
                    c_f3_and:     w_alu_op = ALU_AND;
                    default:      w_alu_op = ALU_ADD;
                endcase
            end
            OPC_LOAD: begin
                w_legal   = w_mem_supported && (w_f3 == c_f3_word);
                w_is_load = w_legal;
            end
            OPC_STORE: begin
                w_legal    = w_mem_supported && (w_f3 == c_f3_word);
                w_is_store = w_legal;
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_is_mem = w_is_load | w_is_store;

    // Memory ops reuse the ALU adder for rs1 + imm.
    assign w_alu_b = w_use_imm ? r_ex_imm : regfile_rsp_rs2_data;

    copperv_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .op     (w_alu_op),
        .a      (regfile_rsp_rs1_data),
        .b      (w_alu_b),
        .result (w_alu_result)
    );

    assign w_in_ex      = (r_state == EXU_EX) && r_ex_valid;
    assign w_rd_nonzero = (r_ex_rd != '0);
    assign w_accept     = instr_valid && instr_ready;
    assign w_cmd_fire   = !rst && w_in_ex && w_is_mem;
    assign w_alu_wb     = w_in_ex && w_legal && !w_is_mem && w_rd_nonzero;
    // Responses are honoured only in MEM_WAIT; one arriving alongside the
    // command (EX) or while idle is dropped.
    assign w_load_wb    = (r_state == EXU_MEM_WAIT) && bus_rsp_ready &&
                          w_is_load && w_rd_nonzero;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            EXU_IDLE: begin
                if (w_accept) w_state_next = EXU_EX;
            end
            EXU_EX: begin
                if (w_is_mem)      w_state_next = EXU_MEM_WAIT;
                else if (w_accept) w_state_next = EXU_EX;
                else               w_state_next = EXU_IDLE;
            end
            EXU_MEM_WAIT: begin
                if (bus_rsp_ready) w_state_next = EXU_IDLE;
            end
            default: w_state_next = EXU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= EXU_IDLE;
            r_ex_valid  <= 1'b0;
            r_ex_opcode <= RESERVED_4;
            r_ex_rd     <= '0;
            r_ex_imm    <= '0;
            r_ex_funct  <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
        end else begin
            r_state    <= w_state_next;
            r_ex_valid <= w_accept;
            if (w_accept) begin
                r_ex_opcode <= instr_opcode;
                r_ex_rd     <= instr_rd;
                r_ex_imm    <= instr_imm;
                r_ex_funct  <= instr_funct;
            end
            if (w_cmd_fire) begin
                r_bus_addr  <= w_alu_result;
                r_bus_wdata <= regfile_rsp_rs2_data;
            end
        end
    end

    // Outputs are forced to their idle values while rst is held so they are
    // defined even before the first reset edge.
    assign instr_ready = rst || (r_state == EXU_IDLE) ||
                         ((r_state == EXU_EX) && !w_is_mem);

    assign bus_cmd_en    = w_cmd_fire;
    assign bus_cmd_we    = w_cmd_fire && w_is_store;
    assign bus_cmd_addr  = rst ? '0 : (w_cmd_fire ? w_alu_result : r_bus_addr);
    assign bus_cmd_wdata = rst ? '0 : (w_cmd_fire ? regfile_rsp_rs2_data : r_bus_wdata);

    assign regfile_cmd_rs1     = instr_rs1;
    assign regfile_cmd_rs2     = instr_rs2;
    assign regfile_cmd_rd      = r_ex_rd;
    assign regfile_cmd_rd_en   = !rst && (w_alu_wb || w_load_wb);
    assign regfile_cmd_rd_data = (r_state == EXU_MEM_WAIT) ? bus_rsp_rdata : w_alu_result;

    assign illegal_instr = !rst && w_in_ex && !w_legal;

endmodule
`default_nettype wire

// File: tb/tb_execution_unit_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_execution_unit_mc
// Description : Directed self-checking bench for execution_unit_mc with a
//               small registered regfile read model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execution_unit_mc;
    import copperv_pkg::*;

    logic        clk;
    logic        rst;
    opcode_e     instr_opcode;
    logic [4:0]  instr_rd, instr_rs1, instr_rs2;
    logic [31:0] instr_imm;
    logic [9:0]  instr_funct;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] bus_cmd_addr, bus_cmd_wdata;
    logic        bus_cmd_en, bus_cmd_we;
    logic [31:0] bus_rsp_rdata;
    logic        bus_rsp_ready;
    logic [4:0]  regfile_cmd_rs1, regfile_cmd_rs2, regfile_cmd_rd;
    logic [31:0] regfile_cmd_rd_data;
    logic        regfile_cmd_rd_en;
    logic [31:0] regfile_rsp_rs1_data, regfile_rsp_rs2_data;
    logic        illegal_instr;

    int tests_run;
    int tests_failed;

    logic [31:0] reg_val [32];

    execution_unit_mc #(
        .XLEN   (32),
        .REG_AW (5),
        .MEM_EN (1)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .instr_opcode         (instr_opcode),
        .instr_rd             (instr_rd),
        .instr_rs1            (instr_rs1),
        .instr_rs2            (instr_rs2),
        .instr_imm            (instr_imm),
        .instr_funct          (instr_funct),
        .instr_valid          (instr_valid),
        .instr_ready          (instr_ready),
        .bus_cmd_addr         (bus_cmd_addr),
        .bus_cmd_wdata        (bus_cmd_wdata),
        .bus_cmd_en           (bus_cmd_en),
        .bus_cmd_we           (bus_cmd_we),
        .bus_rsp_rdata        (bus_rsp_rdata),
        .bus_rsp_ready        (bus_rsp_ready),
        .regfile_cmd_rs1      (regfile_cmd_rs1),
        .regfile_cmd_rs2      (regfile_cmd_rs2),
        .regfile_cmd_rd       (regfile_cmd_rd),
        .regfile_cmd_rd_data  (regfile_cmd_rd_data),
        .regfile_cmd_rd_en    (regfile_cmd_rd_en),
        .regfile_rsp_rs1_data (regfile_rsp_rs1_data),
        .regfile_rsp_rs2_data (regfile_rsp_rs2_data),
        .illegal_instr        (illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file read port: data one cycle after the address.
    always @(posedge clk) begin
        regfile_rsp_rs1_data <= reg_val[regfile_cmd_rs1];
        regfile_rsp_rs2_data <= reg_val[regfile_cmd_rs2];
    end

    task automatic drive(input opcode_e op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm, input logic [9:0] funct);
        instr_opcode = op;
        instr_rd     = rd;
        instr_rs1    = rs1;
        instr_rs2    = rs2;
        instr_imm    = imm;
        instr_funct  = funct;
        instr_valid  = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (instr_ready !== 1'b1 || bus_cmd_en !== 1'b0 || bus_cmd_we !== 1'b0 ||
            regfile_cmd_rd_en !== 1'b0 || illegal_instr !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: ready=%b en=%b we=%b rd_en=%b ill=%b, required 1 0 0 0 0",
                     instr_ready, bus_cmd_en, bus_cmd_we, regfile_cmd_rd_en, illegal_instr);
        end
        tests_run++;
        if (bus_cmd_addr !== 32'h0 || bus_cmd_wdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_bus: addr=%h wdata=%h, required 0 0", bus_cmd_addr, bus_cmd_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if (instr_ready !== 1'b1 || bus_cmd_en !== 1'b0 || regfile_cmd_rd_en !== 1'b0 ||
            illegal_instr !== 1'b0 || bus_cmd_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL post_reset: ready=%b en=%b rd_en=%b ill=%b addr=%h, required 1 0 0 0 0",
                     instr_ready, bus_cmd_en, regfile_cmd_rd_en, illegal_instr, bus_cmd_addr);
        end
    endtask

    task automatic test_addi();
        @(negedge clk);
        drive(OPC_OP_IMM, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFD, 10'h000);
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        tests_run++;
        if (regfile_cmd_rd_en !== 1'b1 || regfile_cmd_rd !== 5'd1 || regfile_cmd_rd_data !== 32'd2) begin
            tests_failed++;
            $display("FAIL addi_wb: rd_en=%b rd=%0d data=%h, required 1 1 00000002",
                     regfile_cmd_rd_en, regfile_cmd_rd, regfile_cmd_rd_data);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (regfile_cmd_rd_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL addi_one_cycle: rd_en=%b, required 0", regfile_cmd_rd_en);
        end
    endtask

    typedef struct {
        opcode_e     op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [9:0]  funct;
        logic [31:0] exp;
    } alu_vec_t;

    // Back-to-back ALU ops; each result is checked the cycle after issue.
    task automatic test_back_to_back();
        alu_vec_t v [12];
        v[0]  = '{OPC_OP,     5'd5,  5'd3,  5'd4,  32'h0,         {7'h20, 3'b000}, 32'h7FFF_FFFF};
        v[1]  = '{OPC_OP,     5'd6,  5'd3,  5'd4,  32'h0,         {7'h00, 3'b010}, 32'h1};
        v[2]  = '{OPC_OP,     5'd7,  5'd3,  5'd4,  32'h0,         {7'h00, 3'b011}, 32'h0};
        v[3]  = '{OPC_OP,     5'd8,  5'd3,  5'd4,  32'h0,         {7'h20, 3'b101}, 32'hC000_0000};
        v[4]  = '{OPC_OP,     5'd9,  5'd3,  5'd4,  32'h0,         {7'h00, 3'b101}, 32'h4000_0000};
        v[5]  = '{OPC_OP_IMM, 5'd10, 5'd5,  5'd0,  32'hFFFF_FFFF, {7'h00, 3'b100}, 32'h0F0F_0F0F};
        v[6]  = '{OPC_OP_IMM, 5'd11, 5'd4,  5'd0,  32'd31,        {7'h00, 3'b001}, 32'h8000_0000};
        v[7]  = '{OPC_OP_IMM, 5'd12, 5'd5,  5'd0,  32'd4,         {7'h20, 3'b101}, 32'hFF0F_0F0F};
        v[8]  = '{OPC_OP_IMM, 5'd13, 5'd5,  5'd0,  32'hFF,        {7'h00, 3'b111}, 32'h0000_00F0};
        v[9]  = '{OPC_OP_IMM, 5'd14, 5'd2,  5'd0,  32'hFFFF_FFFF, {7'h00, 3'b011}, 32'h1};
        v[10] = '{OPC_OP,     5'd15, 5'd3,  5'd3,  32'h0,         {7'h00, 3'b000}, 32'h0};
        v[11] = '{OPC_OP,     5'd16, 5'd4,  5'd17, 32'h0,         {7'h00, 3'b001}, 32'h2};
        for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            if (i < 12) drive(v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm, v[i].funct);
            else        instr_valid = 1'b0;
            #1;
            if (i > 0) begin
                tests_run++;
                if (regfile_cmd_rd_en !== 1'b1 || regfile_cmd_rd !== v[i-1].rd ||
                    regfile_cmd_rd_data !== v[i-1].exp) begin
                    tests_failed++;
                    $display("FAIL alu_vec%0d: rd_en=%b rd=%0d data=%h, required 1 %0d %h",
                             i-1, regfile_cmd_rd_en, regfile_cmd_rd, regfile_cmd_rd_data,
                             v[i-1].rd, v[i-1].exp);
                end
                tests_run++;
                if (instr_ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL alu_ready%0d: ready=%b, required 1", i-1, instr_ready);
                end
            end
        end
    endtask

    task automatic test_load();
        int low_cnt;
        low_cnt = 0;
        @(negedge clk);
        drive(OPC_LOAD, 5'd21, 5'd20, 5'd0, 32'd4, {7'h00, 3'b010});
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        if (instr_ready === 1'b0) low_cnt++;
        tests_run++;
        if (bus_cmd_en !== 1'b1 || bus_cmd_we !== 1'b0 || bus_cmd_addr !== 32'h104 ||
            regfile_cmd_rd_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL lw_cmd: en=%b we=%b addr=%h rd_en=%b, required 1 0 00000104 0",
                     bus_cmd_en, bus_cmd_we, bus_cmd_addr, regfile_cmd_rd_en);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            if (instr_ready === 1'b0) low_cnt++;
            tests_run++;
            if (bus_cmd_en !== 1'b0 || bus_cmd_addr !== 32'h104 || regfile_cmd_rd_en !== 1'b0) begin
                tests_failed++;
                $display("FAIL lw_wait%0d: en=%b addr=%h rd_en=%b, required 0 00000104 0",
                         c, bus_cmd_en, bus_cmd_addr, regfile_cmd_rd_en);
            end
        end
        @(negedge clk);
        bus_rsp_ready = 1'b1;
        bus_rsp_rdata = 32'hDEAD_BEEF;
        #1;
        if (instr_ready === 1'b0) low_cnt++;
        tests_run++;
        if (regfile_cmd_rd_en !== 1'b1 || regfile_cmd_rd !== 5'd21 ||
            regfile_cmd_rd_data !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL lw_wb: rd_en=%b rd=%0d data=%h, required 1 21 deadbeef",
                     regfile_cmd_rd_en, regfile_cmd_rd, regfile_cmd_rd_data);
        end
        @(negedge clk);
        bus_rsp_ready = 1'b0;
        #1;
        if (instr_ready === 1'b0) low_cnt++;
        tests_run++;
        if (low_cnt != 4 || regfile_cmd_rd_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL lw_ready_low: cycles=%0d rd_en=%b, required 4 0", low_cnt, regfile_cmd_rd_en);
        end
    endtask

    task automatic test_store();
        @(negedge clk);
        drive(OPC_STORE, 5'd0, 5'd22, 5'd23, 32'd8, {7'h00, 3'b010});
        @(negedge clk);
        instr_valid   = 1'b0;
        bus_rsp_ready = 1'b1;   // must not complete in the command cycle
        #1;
        tests_run++;
        if (bus_cmd_en !== 1'b1 || bus_cmd_we !== 1'b1 || bus_cmd_addr !== 32'h208 ||
            bus_cmd_wdata !== 32'h1234 || regfile_cmd_rd_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL sw_cmd: en=%b we=%b addr=%h wdata=%h rd_en=%b, required 1 1 00000208 00001234 0",
                     bus_cmd_en, bus_cmd_we, bus_cmd_addr, bus_cmd_wdata, regfile_cmd_rd_en);
        end
        @(negedge clk);
        bus_rsp_ready = 1'b0;
        #1;
        tests_run++;
        if (instr_ready !== 1'b0 || bus_cmd_wdata !== 32'h1234 || bus_cmd_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL sw_early_ack: ready=%b wdata=%h en=%b, required 0 00001234 0",
                     instr_ready, bus_cmd_wdata, bus_cmd_en);
        end
        @(negedge clk);
        bus_rsp_ready = 1'b1;
        #1;
        tests_run++;
        if (instr_ready !== 1'b0 || regfile_cmd_rd_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL sw_ack: ready=%b rd_en=%b, required 0 0", instr_ready, regfile_cmd_rd_en);
        end
        @(negedge clk);
        bus_rsp_ready = 1'b0;
        #1;
        tests_run++;
        if (instr_ready !== 1'b1 || regfile_cmd_rd_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL sw_done: ready=%b rd_en=%b, required 1 0", instr_ready, regfile_cmd_rd_en);
        end
    endtask

    task automatic test_illegal();
        int pulses;
        pulses = 0;
        @(negedge clk);
        drive(OPC_OP_IMM, 5'd0, 5'd2, 5'd0, 32'd1, 10'h000);
        @(negedge clk);
        drive(OPC_OP, 5'd9, 5'd3, 5'd4, 32'h0, {7'h01, 3'b000});
        #1;
        if (illegal_instr === 1'b1) pulses++;
        tests_run++;
        if (regfile_cmd_rd_en !== 1'b0 || illegal_instr !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd0_suppress: rd_en=%b ill=%b, required 0 0", regfile_cmd_rd_en, illegal_instr);
        end
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        if (illegal_instr === 1'b1) pulses++;
        tests_run++;
        if (regfile_cmd_rd_en !== 1'b0 || illegal_instr !== 1'b1 || bus_cmd_en !== 1'b0 ||
            instr_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bad_funct: rd_en=%b ill=%b en=%b ready=%b, required 0 1 0 1",
                     regfile_cmd_rd_en, illegal_instr, bus_cmd_en, instr_ready);
        end
        @(negedge clk);
        #1;
        if (illegal_instr === 1'b1) pulses++;
        tests_run++;
        if (pulses != 1) begin
            tests_failed++;
            $display("FAIL illegal_pulses: count=%0d, required 1", pulses);
        end
        drive(OPC_LUI, 5'd9, 5'd0, 5'd0, 32'h0, 10'h000);
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        tests_run++;
        if (illegal_instr !== 1'b1 || regfile_cmd_rd_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL bad_opcode: ill=%b rd_en=%b, required 1 0", illegal_instr, regfile_cmd_rd_en);
        end
    endtask

    task automatic test_reset_mem_wait();
        @(negedge clk);
        drive(OPC_LOAD, 5'd24, 5'd20, 5'd0, 32'd0, {7'h00, 3'b010});
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        tests_run++;
        if (bus_cmd_en !== 1'b1 || bus_cmd_addr !== 32'h100) begin
            tests_failed++;
            $display("FAIL rst_lw_cmd: en=%b addr=%h, required 1 00000100", bus_cmd_en, bus_cmd_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if (instr_ready !== 1'b1 || regfile_cmd_rd_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_during: ready=%b rd_en=%b, required 1 0", instr_ready, regfile_cmd_rd_en);
        end
        @(negedge clk);
        rst           = 1'b0;
        bus_rsp_ready = 1'b1;
        bus_rsp_rdata = 32'h0000_0055;
        #1;
        tests_run++;
        if (regfile_cmd_rd_en !== 1'b0 || instr_ready !== 1'b1 || bus_cmd_en !== 1'b0 ||
            bus_cmd_addr !== 32'h0 || bus_cmd_wdata !== 32'h0 || illegal_instr !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_abandon: rd_en=%b ready=%b en=%b addr=%h wdata=%h ill=%b, required 0 1 0 0 0 0",
                     regfile_cmd_rd_en, instr_ready, bus_cmd_en, bus_cmd_addr, bus_cmd_wdata, illegal_instr);
        end
        @(negedge clk);
        bus_rsp_ready = 1'b0;
        #1;
        tests_run++;
        if (regfile_cmd_rd_en !== 1'b0 || instr_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_after: rd_en=%b ready=%b, required 0 1", regfile_cmd_rd_en, instr_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        for (int r = 0; r < 32; r++) reg_val[r] = 32'h0;
        reg_val[2]  = 32'd5;
        reg_val[3]  = 32'h8000_0000;
        reg_val[4]  = 32'd1;
        reg_val[5]  = 32'hF0F0_F0F0;
        reg_val[17] = 32'd33;
        reg_val[20] = 32'h100;
        reg_val[22] = 32'h200;
        reg_val[23] = 32'h1234;
        rst           = 1'b1;
        instr_opcode  = OPC_OP_IMM;
        instr_rd      = '0;
        instr_rs1     = '0;
        instr_rs2     = '0;
        instr_imm     = '0;
        instr_funct   = '0;
        instr_valid   = 1'b0;
        bus_rsp_rdata = '0;
        bus_rsp_ready = 1'b0;

        test_reset();
        test_addi();
        test_back_to_back();
        test_load();
        test_store();
        test_illegal();
        test_reset_mem_wait();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/execution_unit_mc.md
EXECUTION_UNIT_MC -- requirements
Module: execution_unit_mc

Interface
REQ-001 Parameter XLEN, default 32, datapath/bus/register data width.
REQ-002 Parameter REG_AW, default 5, register address width.
REQ-003 Parameter MEM_EN, default 1, enables LOAD/STORE handling; 0 treats them as illegal.
REQ-004 clk  in  1  sole clock; one clock, all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 instr_opcode  in  opcode_e  decoded opcode.
REQ-007 instr_rd / instr_rs1 / instr_rs2  in  REG_AW  register indices.
REQ-008 instr_imm  in  XLEN  sign-extended immediate.
REQ-009 instr_funct  in  10  {funct7, funct3}.
REQ-010 instr_valid  in  1 / instr_ready  out  1  instruction handshake; transfer when both high.
REQ-011 bus_cmd_addr, bus_cmd_wdata  out  XLEN; bus_cmd_en, bus_cmd_we  out  1  memory command.
REQ-012 bus_rsp_rdata  in  XLEN; bus_rsp_ready  in  1  response/ack valid.
REQ-013 regfile_cmd_rs1/rs2/rd  out  REG_AW; regfile_cmd_rd_data  out  XLEN; regfile_cmd_rd_en  out  1.
REQ-014 regfile_rsp_rs1_data/rs2_data  in  XLEN, valid one cycle after address presented.
REQ-015 illegal_instr  out  1  one-cycle pulse on unsupported opcode/funct.

Function
REQ-016 regfile_cmd_rs1/rs2 SHALL combinationally follow instr_rs1/rs2; accepted instruction is registered into EX stage with ex_valid.
REQ-017 FSM states IDLE, EX, MEM_WAIT; IDLE->EX on accept; EX->EX on accept of non-memory op; EX->IDLE when no accept; EX->MEM_WAIT for LOAD/STORE; MEM_WAIT->IDLE on bus_rsp_ready.
REQ-018 instr_ready SHALL be 1 in IDLE, 1 in EX for non-memory ops, 0 in EX for memory ops and 0 in MEM_WAIT.
REQ-019 OP_IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI; OP: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, per RV32I semantics at XLEN.
REQ-020 Shift amount = low log2(XLEN) bits of operand 2; comparisons yield 0/1 zero-extended; add/sub wrap modulo 2^XLEN.
REQ-021 ALU result SHALL write back in EX cycle: rd_en=1 for exactly one cycle, rd=ex rd; suppressed when rd==0.
REQ-022 LOAD (word): in EX assert bus_cmd_en=1, we=0, addr=rs1+imm for one cycle; on bus_rsp_ready in MEM_WAIT write bus_rsp_rdata to rd (rd!=0) same cycle.
REQ-023 STORE (word): in EX assert bus_cmd_en=1, we=1, addr=rs1+imm, wdata=rs2 for one cycle; MEM_WAIT ends on bus_rsp_ready; no writeback.
REQ-024 bus_rsp_ready outside MEM_WAIT SHALL be ignored.
REQ-025 bus_rsp_ready in the same cycle bus_cmd_en is asserted SHALL NOT complete the access; completion only from MEM_WAIT.
REQ-026 Unsupported opcode/funct: no writeback, no bus command, illegal_instr pulse in EX cycle, pipeline continues.
REQ-027 Back-to-back ALU ops: one instruction per cycle, no bubbles.
REQ-028 bus_cmd_addr/wdata SHALL hold value from EX through MEM_WAIT.

Reset
REQ-029 On rst: state=IDLE, ex_valid=0, ex opcode=RESERVED_4, all EX fields 0.
REQ-030 During/after reset: instr_ready=1, bus_cmd_en=0, bus_cmd_we=0, regfile_cmd_rd_en=0, illegal_instr=0, bus_cmd_addr/wdata=0.
REQ-031 rst asserted in MEM_WAIT SHALL abandon access; a later bus_rsp_ready SHALL cause no writeback.

Structure
REQ-032 copperv_pkg SHALL hold extended alu_op_e, funct constants, and exu_state_e enum.
REQ-033 ALU SHALL be a separate sub-module, copperv_alu, parametrised by XLEN.

Verification
REQ-034 ADDI rd=1, rs1 data=5, imm=-3 -> next cycle rd_en=1, rd=1, rd_data=2.
REQ-035 SUB, SLT with rs1=0x8000_0000, rs2=1 -> SUB 0x7FFF_FFFF; SLT 1; SLTU 0.
REQ-036 LW rs1=0x100, imm=4, response after 3 cycles with 0xDEAD_BEEF -> cmd_en pulse addr 0x104, instr_ready low 4 cycles, rd_data 0xDEAD_BEEF.
REQ-037 SW rs2=0x1234, bus_rsp_ready same cycle as cmd_en then 2 cycles later -> completes on second, we=1, no rd_en.
REQ-038 ADDI rd=0 then unsupported funct -> no rd_en either cycle; illegal_instr pulse once.
REQ-039 rst mid-MEM_WAIT, then bus_rsp_ready -> outputs at reset values, no writeback, instr_ready=1.
